// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART receive frame controller.
// Contents: frame FSM state enum, default parameter values, buffer pointer width helper.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StCsum,
        StSend
    } frame_state_e;

    localparam int unsigned DefMaxLen     = 16;
    localparam logic [7:0]  DefSofByte    = 8'hA5;
    localparam int unsigned DefTimeoutCyc = 52080;

    // Pointer width for a buffer of max_len entries; never narrower than one bit.
    function automatic int unsigned ptr_width(int unsigned max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload stream from the frame controller to the speech-command decoder.
// Signals: out_data/out_valid/out_last/pkt_len driven by the controller (master),
//          out_ready driven by the consumer (slave).
interface uart_rx_frame_ctrl_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] pkt_len;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output pkt_len,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  pkt_len,
        output out_ready
    );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
// No reset: contents are only read after being written within the same frame.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: SOF, LEN, payload, checksum framing of receiver bytes,
// buffering of validated payloads and streaming over a valid/ready interface.
// Ports: clk, rst_n (async active-low), rx_data/rx_busy (receiver), out_if (payload stream,
//        master modport), busy, frame_ok_cnt, err_csum/err_len/err_ovr/err_tmo (pulses).
// Optional: UART_FRAME_TIMEOUT_EN adds an inter-byte timeout in LEN/PAYLOAD/CSUM;
//           without it err_tmo stays 0 and a stalled frame waits indefinitely.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN     = DefMaxLen,
    parameter logic [7:0]  SOF_BYTE    = DefSofByte,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_busy,
    uart_rx_frame_ctrl_if.master out_if,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_ok_cnt,
    output logic                 err_csum,
    output logic                 err_len,
    output logic                 err_ovr,
    output logic                 err_tmo
);
    localparam int unsigned PtrW = ptr_width(MAX_LEN);

    frame_state_e      state_q;
    logic              busy_q;
    logic [7:0]        len_q;
    logic [7:0]        csum_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  ok_cnt_q;
    logic              err_csum_q, err_len_q, err_ovr_q, err_tmo_q;

    logic              strobe;
    logic              tmo_hit;
    logic              rd_last;
    logic [7:0]        rd_data;

    // Byte complete is the falling edge of the receiver busy flag.
    assign strobe  = busy_q & ~rx_busy;
    assign rd_last = (8'(rd_ptr_q) == len_q - 8'd1);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            in_frame;

    assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
    // A strobe in the expiry cycle wins over the timeout.
    assign tmo_hit  = in_frame && !strobe && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

    // Held at zero outside the frame states, so entry always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (!in_frame || strobe || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .PTR_W (PtrW)
    ) u_buf (
        .clk   (clk),
        .we    (strobe && (state_q == StPayload)),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            len_q       <= '0;
            csum_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            ok_cnt_q    <= '0;
            err_csum_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            busy_q     <= rx_busy;
            err_csum_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (strobe && (rx_data == SOF_BYTE)) begin
                        csum_q  <= '0;
                        state_q <= StLen;
                    end
                end
                StLen: begin
                    if (strobe) begin
                        if ((rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN))) begin
                            len_q    <= rx_data;
                            csum_q   <= rx_data;
                            wr_ptr_q <= '0;
                            state_q  <= StPayload;
                        end else begin
                            err_len_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StPayload: begin
                    if (strobe) begin
                        csum_q   <= csum_q ^ rx_data;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (8'(wr_ptr_q) == len_q - 8'd1) begin
                            state_q <= StCsum;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StCsum: begin
                    if (strobe) begin
                        if (rx_data == csum_q) begin
                            rd_ptr_q    <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= StSend;
                            if (ok_cnt_q != {CNT_W{1'b1}}) begin
                                ok_cnt_q <= ok_cnt_q + 1'b1;
                            end
                        end else begin
                            err_csum_q <= 1'b1;
                            state_q    <= StIdle;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StSend: begin
                    // Bytes arriving while streaming are dropped, never checked for SOF.
                    if (strobe) begin
                        err_ovr_q <= 1'b1;
                    end
                    if (out_if.out_ready) begin
                        if (rd_last) begin
                            rd_ptr_q    <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stream outputs are gated by valid so they read as zero when idle or in reset.
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_valid_q ? rd_data : 8'd0;
    assign out_if.out_last  = out_valid_q & rd_last;
    assign out_if.pkt_len   = out_valid_q ? len_q : 8'd0;

    assign busy         = (state_q != StIdle);
    assign frame_ok_cnt = ok_cnt_q;
    assign err_csum     = err_csum_q;
    assign err_len      = err_len_q;
    assign err_ovr      = err_ovr_q;
    assign err_tmo      = err_tmo_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected payload bytes,
// a negedge monitor compares every presented byte and counts error pulses.
module tb_uart_rx_frame_ctrl;
    localparam int unsigned TmoCyc = 200;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_busy = 1'b0;
    logic        busy;
    logic [15:0] frame_ok_cnt;
    logic        err_csum, err_len, err_ovr, err_tmo;

    uart_rx_frame_ctrl_if sb ();

    uart_rx_frame_ctrl #(
        .MAX_LEN     (16),
        .SOF_BYTE    (8'hA5),
        .TIMEOUT_CYC (TmoCyc),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_busy      (rx_busy),
        .out_if       (sb),
        .busy         (busy),
        .frame_ok_cnt (frame_ok_cnt),
        .err_csum     (err_csum),
        .err_len      (err_len),
        .err_ovr      (err_ovr),
        .err_tmo      (err_tmo)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [7:0] fr[$];
    int   c_csum = 0, c_len = 0, c_ovr = 0, c_tmo = 0;
    int   e_csum = 0, e_len = 0, e_ovr = 0, e_tmo = 0;
    int   exp_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares the presented byte every cycle (covers hold during stall).
    always @(negedge clk) begin
        if (rst_n) begin
            c_csum += int'(err_csum);
            c_len  += int'(err_len);
            c_ovr  += int'(err_ovr);
            c_tmo  += int'(err_tmo);
            if (sb.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", 32'(sb.out_data), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(sb.out_data), 32'(exp_q[0].data));
                    check("out_last", 32'(sb.out_last), 32'(exp_q[0].last));
                    check("pkt_len", 32'(sb.pkt_len), 32'(exp_q[0].len));
                    if (sb.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_busy = 1'b1;
        rx_data = b;
        repeat (3) @(posedge clk);
        #1 rx_busy = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_fr();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    // Expected stream: fr = {SOF, LEN, payload..., csum}.
    task automatic good_frame();
        int n;
        exp_t e;
        n = int'(fr[1]);
        for (int i = 0; i < n; i++) begin
            e.data = fr[2+i];
            e.last = (i == n - 1);
            e.len  = fr[1];
            exp_q.push_back(e);
        end
        exp_ok++;
        send_fr();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_errs(input string tag);
        check({tag, " err_csum pulses"}, 32'(c_csum), 32'(e_csum));
        check({tag, " err_len pulses"}, 32'(c_len), 32'(e_len));
        check({tag, " err_ovr pulses"}, 32'(c_ovr), 32'(e_ovr));
        check({tag, " err_tmo pulses"}, 32'(c_tmo), 32'(e_tmo));
        check({tag, " frame_ok_cnt"}, 32'(frame_ok_cnt), 32'(exp_ok));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sb.out_ready = 1'b1;
        #12;
        check("reset out_valid", 32'(sb.out_valid), 32'd0);
        check("reset out_data", 32'(sb.out_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_ok_cnt", 32'(frame_ok_cnt), 32'd0);
        check("reset err pulses", 32'({err_csum, err_len, err_ovr, err_tmo}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Good frame preceded by a stray byte that must be ignored in IDLE.
        send_byte(8'h33);
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        good_frame();
        wait_drain("f1 drain");
        check("f1 busy after", 32'(busy), 32'd0);
        check_errs("f1");

        // Bad checksum, then the good frame again.
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
        send_fr();
        e_csum++;
        check_errs("bad csum");
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        good_frame();
        wait_drain("f2 drain");
        check_errs("f2");

        // LEN = 0 and LEN = MAX_LEN+1, then a one-byte frame.
        fr = '{8'hA5, 8'h00};
        send_fr();
        e_len++;
        fr = '{8'hA5, 8'h11};
        send_fr();
        e_len++;
        check_errs("bad len");
        fr = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        good_frame();
        wait_drain("f3 drain");
        check_errs("f3");

        // LEN = MAX_LEN with bytes 00..0F (includes a zero data byte).
        fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
               8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        good_frame();
        wait_drain("max len drain");
        check_errs("max len");

        // Stalled stream plus an overrun byte; payload must stream intact afterwards.
        sb.out_ready = 1'b0;
        fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        good_frame();
        repeat (5) @(posedge clk);
        #1 check("stall out_valid", 32'(sb.out_valid), 32'd1);
        send_byte(8'h55);
        e_ovr++;
        check_errs("overrun");
        check("stall queue intact", 32'(exp_q.size()), 32'd2);
        @(posedge clk); #1 sb.out_ready = 1'b1;
        wait_drain("overrun drain");
        check_errs("after overrun");

        // Stalled frame: LEN=4 with only one payload byte.
        fr = '{8'hA5, 8'h04, 8'h01};
        send_fr();
        repeat (TmoCyc + 10) @(posedge clk);
        #1;
`ifdef UART_FRAME_TIMEOUT_EN
        e_tmo++;
        check("tmo busy fell", 32'(busy), 32'd0);
        check_errs("timeout");
        fr = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        good_frame();
        wait_drain("post tmo drain");
        check_errs("post tmo");
        fr = '{8'hA5, 8'h04, 8'h01};
        send_fr();
`else
        check("no tmo busy held", 32'(busy), 32'd1);
        check_errs("no timeout");
`endif
        // Reset mid-PAYLOAD for one cycle.
        check("mid payload busy", 32'(busy), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset out_valid", 32'(sb.out_valid), 32'd0);
        check("mid reset frame_ok_cnt", 32'(frame_ok_cnt), 32'd0);
        check("mid reset err pulses", 32'({err_csum, err_len, err_ovr, err_tmo}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_ok = 0;
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        good_frame();
        wait_drain("post reset drain");
        check_errs("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
